hall_call_dispatcher: RTL and testbench

- Scheduler that latches hall calls from floors 1..7 and assigns each call to one of the two cars.
- It tracks one outstanding target floor per car, retires a call when its car arrives, and re-dispatches calls whose car goes into emergency.
- It sits between the passenger/floor inputs and the car-motion logic, sequencing which floor each car serves next.

---
 rtl/hall_call_dispatcher.sv | 167 ++++++++++++++++
 tb/tb_hall_call_dispatcher.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hall_call_dispatcher.sv
// Two-car hall-call dispatcher: latches floor calls, scans them round-robin and
// hands each unassigned call to the nearer eligible car, retiring it on arrival.
module hall_call_dispatcher #(
  parameter int unsigned FLOORS  = 7,
  parameter int unsigned FLOOR_W = 3
) (
  input  logic               clock,
  input  logic               reset_start,
  input  logic [FLOORS-1:0]  call_up,
  input  logic [FLOORS-1:0]  call_down,
  input  logic [FLOOR_W-1:0] curr_elevator_1,
  input  logic [FLOOR_W-1:0] curr_elevator_2,
  input  logic [1:0]         emergency,
  output logic [FLOOR_W-1:0] target_1,
  output logic [FLOOR_W-1:0] target_2,
  output logic               target_valid_1,
  output logic               target_valid_2,
  output logic               arrive_1,
  output logic               arrive_2,
  output logic [FLOORS-1:0]  pending,
  output logic [2:0]         pending_count,
  output logic               dispatch_busy
);

  typedef enum logic [1:0] {IDLE, SCAN, ASSIGN, WAIT} state_t;

  state_t               state_q, state_d;
  logic [FLOOR_W-1:0]   ptr_q, ptr_d, cand_q, cand_d;
  logic [FLOORS-1:0]    pending_q, pending_d, assigned_q, assigned_d;
  logic [FLOOR_W-1:0]   tgt1_q, tgt1_d, tgt2_q, tgt2_d;
  logic                 tv1_q, tv1_d, tv2_q, tv2_d;
  logic                 arr1_q, arr1_d, arr2_q, arr2_d;

  logic                 drop1, drop2, elig1, elig2, pick2;
  logic [FLOORS-1:0]    free, clr_mask, drop_mask, set_mask, ptr_bit, cand_bit;
  logic [FLOOR_W-1:0]   dist1, dist2;
  logic [2:0]           cnt;

  function automatic logic [FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
    floor_bit = '0;
    for (int unsigned i = 0; i < FLOORS; i++)
      if (f == FLOOR_W'(i + 1)) floor_bit[i] = 1'b1;
  endfunction

  function automatic logic [FLOOR_W-1:0] next_floor(input logic [FLOOR_W-1:0] f);
    next_floor = (f >= FLOOR_W'(FLOORS)) ? FLOOR_W'(1) : f + FLOOR_W'(1);
  endfunction

  function automatic logic [FLOOR_W-1:0] abs_diff(input logic [FLOOR_W-1:0] a,
                                                  input logic [FLOOR_W-1:0] b);
    abs_diff = (a >= b) ? a - b : b - a;
  endfunction

  always_comb begin
    // Emergency takes precedence over arrival: a car taken out of service never pulses arrive.
    arr1_d    = tv1_q && !emergency[0] && (curr_elevator_1 == tgt1_q);
    arr2_d    = tv2_q && !emergency[1] && (curr_elevator_2 == tgt2_q);
    drop1     = tv1_q && emergency[0];
    drop2     = tv2_q && emergency[1];
    clr_mask  = (arr1_d ? floor_bit(tgt1_q) : '0) | (arr2_d ? floor_bit(tgt2_q) : '0);
    drop_mask = (drop1 ? floor_bit(tgt1_q) : '0) | (drop2 ? floor_bit(tgt2_q) : '0);
    free      = pending_q & ~assigned_q;
    elig1     = !emergency[0] && !tv1_q;
    elig2     = !emergency[1] && !tv2_q;
    dist1     = abs_diff(curr_elevator_1, cand_q);
    dist2     = abs_diff(curr_elevator_2, cand_q);
    pick2     = elig2 && (!elig1 || (dist2 < dist1));
    ptr_bit   = floor_bit(ptr_q);
    cand_bit  = floor_bit(cand_q);

    state_d  = state_q;
    ptr_d    = ptr_q;
    cand_d   = cand_q;
    tgt1_d   = tgt1_q;
    tgt2_d   = tgt2_q;
    tv1_d    = tv1_q;
    tv2_d    = tv2_q;
    set_mask = '0;

    if (arr1_d || drop1) begin
      tgt1_d = '0;
      tv1_d  = 1'b0;
    end
    if (arr2_d || drop2) begin
      tgt2_d = '0;
      tv2_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: if (|free) state_d = SCAN;
      SCAN: begin
        if (!(|free)) state_d = IDLE;
        else if (|(free & ptr_bit)) begin
          cand_d  = ptr_q;
          state_d = ASSIGN;
        end else ptr_d = next_floor(ptr_q);
      end
      ASSIGN: begin
        // An eligible car has no valid target, so this never collides with the arrival/drop updates above.
        if (elig1 || elig2) begin
          if (pick2) begin
            tgt2_d = cand_q;
            tv2_d  = 1'b1;
          end else begin
            tgt1_d = cand_q;
            tv1_d  = 1'b1;
          end
          set_mask = cand_bit;
          ptr_d    = next_floor(cand_q);
          state_d  = SCAN;
        end else state_d = WAIT;
      end
      WAIT: begin
        if (!(|(pending_q & cand_bit))) state_d = SCAN;
        else if (elig1 || elig2)        state_d = ASSIGN;
      end
      default: state_d = IDLE;
    endcase

    pending_d  = (pending_q | call_up | call_down) & ~clr_mask;
    assigned_d = (assigned_q | set_mask) & ~(clr_mask | drop_mask);
  end

  always_ff @(posedge clock or posedge reset_start) begin
    if (reset_start) begin
      state_q    <= IDLE;
      ptr_q      <= FLOOR_W'(1);
      cand_q     <= '0;
      pending_q  <= '0;
      assigned_q <= '0;
      tgt1_q     <= '0;
      tgt2_q     <= '0;
      tv1_q      <= 1'b0;
      tv2_q      <= 1'b0;
      arr1_q     <= 1'b0;
      arr2_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cand_q     <= cand_d;
      pending_q  <= pending_d;
      assigned_q <= assigned_d;
      tgt1_q     <= tgt1_d;
      tgt2_q     <= tgt2_d;
      tv1_q      <= tv1_d;
      tv2_q      <= tv2_d;
      arr1_q     <= arr1_d;
      arr2_q     <= arr2_d;
    end
  end

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < FLOORS; i++) cnt = cnt + 3'(pending_q[i]);
  end

  assign target_1       = tgt1_q;
  assign target_2       = tgt2_q;
  assign target_valid_1 = tv1_q;
  assign target_valid_2 = tv2_q;
  assign arrive_1       = arr1_q;
  assign arrive_2       = arr2_q;
  assign pending        = pending_q;
  assign pending_count  = cnt;
  assign dispatch_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_hall_call_dispatcher.sv
// Bench for hall_call_dispatcher: assignment vectors from a table plus hand-written
// arrival, emergency, wait and clear-priority sequences; assignments go through a scoreboard.
module tb_hall_call_dispatcher;

  logic       clock = 1'b0;
  logic       reset_start;
  logic [6:0] call_up, call_down;
  logic [2:0] curr_elevator_1, curr_elevator_2;
  logic [1:0] emergency;
  logic [2:0] target_1, target_2;
  logic       target_valid_1, target_valid_2, arrive_1, arrive_2;
  logic [6:0] pending;
  logic [2:0] pending_count;
  logic       dispatch_busy;

  hall_call_dispatcher #(.FLOORS(7), .FLOOR_W(3)) dut (
    .clock(clock), .reset_start(reset_start),
    .call_up(call_up), .call_down(call_down),
    .curr_elevator_1(curr_elevator_1), .curr_elevator_2(curr_elevator_2),
    .emergency(emergency),
    .target_1(target_1), .target_2(target_2),
    .target_valid_1(target_valid_1), .target_valid_2(target_valid_2),
    .arrive_1(arrive_1), .arrive_2(arrive_2),
    .pending(pending), .pending_count(pending_count),
    .dispatch_busy(dispatch_busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int n_assign = 0;

  typedef struct {
    int car;
    int floor;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [2:0] c1;
    logic [2:0] c2;
    logic [1:0] em;
    logic [2:0] fl;
    int         car;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic prev_tv1 = 1'b0, prev_tv2 = 1'b0;

  task automatic got_assign(input int car, input int floor);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_assign: got car %0d floor %0d expected none", car, floor);
    end else begin
      e = sb.pop_front();
      check("assign_car", car, e.car);
      check("assign_floor", floor, e.floor);
    end
    n_assign++;
  endtask

  always @(negedge clock) begin
    if (!reset_start) begin
      if (target_valid_1 && !prev_tv1) got_assign(1, int'(target_1));
      if (target_valid_2 && !prev_tv2) got_assign(2, int'(target_2));
    end
    prev_tv1 = target_valid_1;
    prev_tv2 = target_valid_2;
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_start     = 1'b1;
    call_up         = '0;
    call_down       = '0;
    curr_elevator_1 = 3'd1;
    curr_elevator_2 = 3'd7;
    emergency       = '0;
    tick();
    tick();
    reset_start = 1'b0;
    tick();
    n_assign = 0;
    sb.delete();
  endtask

  task automatic wait_assign(input int want, input int budget);
    int k = 0;
    while (n_assign < want && k < budget) begin
      tick();
      k++;
    end
    check("assign_wait", n_assign, want);
  endtask

  function automatic logic [6:0] fbit(input logic [2:0] f);
    logic [6:0] one = 7'd1;
    return one << (f - 3'd1);
  endfunction

  initial begin
    vecs[0] = '{c1: 3'd1, c2: 3'd7, em: 2'b00, fl: 3'd3, car: 1};
    vecs[1] = '{c1: 3'd2, c2: 3'd6, em: 2'b00, fl: 3'd4, car: 1};
    vecs[2] = '{c1: 3'd1, c2: 3'd7, em: 2'b01, fl: 3'd2, car: 2};
    vecs[3] = '{c1: 3'd1, c2: 3'd7, em: 2'b10, fl: 3'd6, car: 1};
    vecs[4] = '{c1: 3'd6, c2: 3'd3, em: 2'b00, fl: 3'd4, car: 2};
    vecs[5] = '{c1: 3'd4, c2: 3'd2, em: 2'b00, fl: 3'd1, car: 2};
    vecs[6] = '{c1: 3'd7, c2: 3'd1, em: 2'b00, fl: 3'd7, car: 1};

    do_reset();
    reset_start = 1'b1;
    #1;
    check("rst_target_1", int'(target_1), 0);
    check("rst_target_2", int'(target_2), 0);
    check("rst_valid_1", int'(target_valid_1), 0);
    check("rst_valid_2", int'(target_valid_2), 0);
    check("rst_arrive", int'({arrive_2, arrive_1}), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_count", int'(pending_count), 0);
    check("rst_busy", int'(dispatch_busy), 0);
    tick();
    reset_start = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      do_reset();
      curr_elevator_1 = vecs[i].c1;
      curr_elevator_2 = vecs[i].c2;
      emergency       = vecs[i].em;
      sb.push_back('{car: vecs[i].car, floor: int'(vecs[i].fl)});
      if (i % 2 == 0) call_up = fbit(vecs[i].fl);
      else            call_down = fbit(vecs[i].fl);
      tick();
      call_up   = '0;
      call_down = '0;
      check("vec_pending", int'(pending), int'(fbit(vecs[i].fl)));
      check("vec_count", int'(pending_count), 1);
      wait_assign(1, 30);
      if (vecs[i].car == 1) check("vec_other_idle", int'(target_valid_2), 0);
      else                  check("vec_other_idle", int'(target_valid_1), 0);
    end

    // Arrival retires the call and the scheduler goes idle.
    do_reset();
    curr_elevator_1 = 3'd2;
    curr_elevator_2 = 3'd6;
    sb.push_back('{car: 1, floor: 4});
    call_up = fbit(3'd4);
    tick();
    call_up = '0;
    wait_assign(1, 30);
    tick();
    tick();
    curr_elevator_1 = 3'd4;
    tick();
    check("arr_pulse", int'(arrive_1), 1);
    check("arr_valid_cleared", int'(target_valid_1), 0);
    check("arr_target_cleared", int'(target_1), 0);
    check("arr_pending", int'(pending), 0);
    tick();
    check("arr_pulse_end", int'(arrive_1), 0);
    check("arr_idle", int'(dispatch_busy), 0);

    // Emergency drops car 1's target; the call is re-dispatched to car 2.
    do_reset();
    curr_elevator_1 = 3'd4;
    curr_elevator_2 = 3'd7;
    sb.push_back('{car: 1, floor: 5});
    call_down = fbit(3'd5);
    tick();
    call_down = '0;
    wait_assign(1, 30);
    sb.push_back('{car: 2, floor: 5});
    emergency = 2'b01;
    tick();
    check("emg_valid", int'(target_valid_1), 0);
    check("emg_target", int'(target_1), 0);
    check("emg_no_arrive", int'(arrive_1), 0);
    check("emg_pending_kept", int'(pending), int'(fbit(3'd5)));
    wait_assign(2, 30);
    check("emg_sb_empty", sb.size(), 0);

    // Three calls with two cars: third waits until car 2 arrives.
    do_reset();
    curr_elevator_1 = 3'd1;
    curr_elevator_2 = 3'd7;
    sb.push_back('{car: 1, floor: 2});
    sb.push_back('{car: 2, floor: 5});
    sb.push_back('{car: 2, floor: 6});
    call_up   = fbit(3'd2) | fbit(3'd5);
    call_down = fbit(3'd6);
    tick();
    call_up   = '0;
    call_down = '0;
    check("wait_count", int'(pending_count), 3);
    wait_assign(2, 40);
    for (int k = 0; k < 5; k++) tick();
    check("wait_busy", int'(dispatch_busy), 1);
    check("wait_both_valid", int'({target_valid_2, target_valid_1}), 3);
    check("wait_pending", int'(pending), int'(7'b0110010));
    curr_elevator_2 = 3'd5;
    wait_assign(3, 40);
    curr_elevator_1 = 3'd2;
    tick();
    check("wait_arrive_1", int'(arrive_1), 1);
    curr_elevator_2 = 3'd6;
    tick();
    check("wait_arrive_2", int'(arrive_2), 1);
    for (int k = 0; k < 4; k++) tick();
    check("wait_drained", int'(pending), 0);
    check("wait_idle", int'(dispatch_busy), 0);

    // Car already at the floor: arrive next cycle; a same-cycle call is cleared.
    do_reset();
    curr_elevator_1 = 3'd3;
    curr_elevator_2 = 3'd7;
    sb.push_back('{car: 1, floor: 3});
    call_up = fbit(3'd3);
    tick();
    call_up = '0;
    wait_assign(1, 30);
    call_up = fbit(3'd3);
    tick();
    call_up = '0;
    check("clr_arrive", int'(arrive_1), 1);
    check("clr_wins", int'(pending), 0);
    check("clr_valid", int'(target_valid_1), 0);
    tick();
    check("clr_pulse_end", int'(arrive_1), 0);
    check("clr_still_clear", int'(pending), 0);
    check("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
